// File: rtl/img2col_flag_seq.sv
// Window-flag sequencer for img2col: a single fill phase, then alternating gap/active
// windows. flag strobes during each active window, and done pulses once at end of map.
module img2col_flag_seq #(
  parameter int CNT_W    = 9,
  parameter int FILL_LEN = 160,
  parameter int GAP_LEN  = 4,
  parameter int ACT_LEN  = 28,
  parameter int ROWS_W   = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              map_finish,
  input  logic              stall,
  input  logic [ROWS_W-1:0] num_rows,
  output logic              flag,
  output logic              busy,
  output logic [ROWS_W-1:0] row_idx,
  output logic              done
);

  if (FILL_LEN < 1 || FILL_LEN > (1 << CNT_W)) begin : g_fill_chk
    $error("FILL_LEN out of range for CNT_W");
  end
  if (GAP_LEN < 1 || GAP_LEN > (1 << CNT_W)) begin : g_gap_chk
    $error("GAP_LEN out of range for CNT_W");
  end
  if (ACT_LEN < 1 || ACT_LEN > (1 << CNT_W)) begin : g_act_chk
    $error("ACT_LEN out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] FILL_TC = CNT_W'(FILL_LEN - 1);
  localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_LEN - 1);
  localparam logic [CNT_W-1:0] ACT_TC  = CNT_W'(ACT_LEN - 1);

  typedef enum logic [1:0] {IDLE, FILL, GAP, ACTIVE} state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic [ROWS_W-1:0] row_d, rows_cap, rows_cap_d, row_inc;
  logic              done_d;

  assign row_inc = row_idx + ROWS_W'(1);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state    <= IDLE;
      cnt      <= '0;
      row_idx  <= '0;
      rows_cap <= '0;
      done     <= 1'b0;
    end else begin
      state    <= state_d;
      cnt      <= cnt_d;
      row_idx  <= row_d;
      rows_cap <= rows_cap_d;
      done     <= done_d;
    end
  end

  always_comb begin
    state_d    = state;
    cnt_d      = cnt;
    row_d      = row_idx;
    rows_cap_d = rows_cap;
    done_d     = 1'b0;
    // map_finish outranks stall; stall freezes everything, including start in IDLE
    if (map_finish) begin
      state_d = IDLE;
      cnt_d   = '0;
      row_d   = '0;
    end else if (!stall) begin
      case (state)
        IDLE: if (start) begin
          state_d    = FILL;
          cnt_d      = '0;
          row_d      = '0;
          rows_cap_d = num_rows;
        end
        FILL: if (cnt == FILL_TC) begin
          state_d = GAP;
          cnt_d   = '0;
        end else cnt_d = cnt + CNT_W'(1);
        GAP: if (cnt == GAP_TC) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end else cnt_d = cnt + CNT_W'(1);
        ACTIVE: if (cnt == ACT_TC) begin
          cnt_d = '0;
          row_d = row_inc;
          // rows_cap==0 runs forever and lets row_idx wrap
          if (rows_cap != '0 && row_inc == rows_cap) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else state_d = GAP;
        end else cnt_d = cnt + CNT_W'(1);
        default: state_d = IDLE;
      endcase
    end
  end

  assign flag = (state == ACTIVE) && !stall;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_img2col_flag_seq.sv
// Directed bench for img2col_flag_seq; cycle c counts edges since the start pulse was sampled.
module tb_img2col_flag_seq;
  logic       clk = 1'b0;
  logic       nrst, start, map_finish, stall;
  logic [7:0] num_rows;
  logic       flag, busy, done;
  logic [7:0] row_idx;
  int         n_tests = 0;
  int         n_fail  = 0;

  img2col_flag_seq dut (
    .clk(clk), .nrst(nrst), .start(start), .map_finish(map_finish), .stall(stall),
    .num_rows(num_rows), .flag(flag), .busy(busy), .row_idx(row_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // pulse start for one cycle; returns at c=1
  task automatic start_map(input int n);
    num_rows = 8'(n);
    start    = 1'b1;
    #1;
    chk("pre_start_busy", 32'(busy), 0);
    tick();
    start    = 1'b0;
    num_rows = 8'd7;
  endtask

  task automatic run_basic(input string tg);
    start_map(2);
    for (int c = 1; c <= 228; c++) begin
      chk($sformatf("%s_flag_c%0d", tg, c), 32'(flag),
          32'((c >= 165 && c <= 192) || (c >= 197 && c <= 224)));
      chk($sformatf("%s_busy_c%0d", tg, c), 32'(busy), 32'(c <= 224));
      chk($sformatf("%s_done_c%0d", tg, c), 32'(done), 32'(c == 225));
      chk($sformatf("%s_row_c%0d", tg, c), 32'(row_idx),
          (c <= 192) ? 0 : (c <= 224) ? 1 : 2);
      tick();
    end
  endtask

  initial begin
    int hi;
    nrst = 1'b0; start = 1'b0; map_finish = 1'b0; stall = 1'b0; num_rows = '0;
    #1;
    chk("rst_flag", 32'(flag), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_row", 32'(row_idx), 0);
    repeat (2) @(posedge clk);
    #3 nrst = 1'b1;
    tick();

    // two-window map, default timing
    run_basic("basic");

    // unlimited rows: 28/4 flag pattern, row_idx wraps 255 -> 0
    start_map(0);
    for (int c = 1; c <= 8400; c++) begin
      chk($sformatf("inf_flag_c%0d", c), 32'(flag),
          32'(c >= 165 && ((c - 165) % 32) < 28));
      chk($sformatf("inf_row_c%0d", c), 32'(row_idx),
          (c < 193) ? 0 : (((c - 193) / 32 + 1) % 256));
      tick();
    end
    map_finish = 1'b1;
    tick();
    map_finish = 1'b0;
    chk("inf_abort_busy", 32'(busy), 0);
    chk("inf_abort_row", 32'(row_idx), 0);
    tick();

    // 5-cycle stall from the 10th active cycle of a one-window map
    start_map(1);
    hi = 0;
    for (int c = 1; c <= 200; c++) begin
      stall = (c >= 174 && c <= 178);
      #1;
      if (flag) hi++;
      chk($sformatf("stall_flag_c%0d", c), 32'(flag),
          32'((c >= 165 && c <= 173) || (c >= 179 && c <= 197)));
      chk($sformatf("stall_done_c%0d", c), 32'(done), 32'(c == 198));
      tick();
    end
    stall = 1'b0;
    chk("stall_flag_count", 32'(hi), 28);

    // map_finish on the 3rd gap cycle of row 1
    start_map(2);
    repeat (194) tick();
    chk("abort_pre_busy", 32'(busy), 1);
    chk("abort_pre_row", 32'(row_idx), 1);
    map_finish = 1'b1;
    tick();
    map_finish = 1'b0;
    for (int c = 196; c <= 230; c++) begin
      chk($sformatf("abort_busy_c%0d", c), 32'(busy), 0);
      chk($sformatf("abort_row_c%0d", c), 32'(row_idx), 0);
      chk($sformatf("abort_done_c%0d", c), 32'(done), 0);
      chk($sformatf("abort_flag_c%0d", c), 32'(flag), 0);
      tick();
    end

    // start held through FILL must not restart the map
    start_map(1);
    start = 1'b1;
    for (int c = 1; c <= 196; c++) begin
      if (c == 161) start = 1'b0;
      #1;
      chk($sformatf("hold_flag_c%0d", c), 32'(flag), 32'(c >= 165 && c <= 192));
      chk($sformatf("hold_done_c%0d", c), 32'(done), 32'(c == 193));
      tick();
    end
    // start together with map_finish in IDLE stays idle
    start = 1'b1; map_finish = 1'b1;
    tick();
    start = 1'b0; map_finish = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("both_busy_%0d", c), 32'(busy), 0);
      tick();
    end

    // async reset on the 5th active cycle, then a clean rerun
    start_map(2);
    repeat (168) tick();
    chk("arst_pre_flag", 32'(flag), 1);
    nrst = 1'b0;
    #1;
    chk("arst_flag", 32'(flag), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    chk("arst_row", 32'(row_idx), 0);
    tick();
    nrst = 1'b1;
    tick();
    chk("arst_idle", 32'(busy), 0);
    run_basic("rerun");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
